// File: rtl/multi_clockdiv.sv
// N-channel programmable 50%-duty clock divider with edge strobes.
// New divisors are staged per channel and applied only on a period boundary.
`timescale 1ns/1ps
module multi_clockdiv #(
    parameter int NCH          = 4,
    parameter int CNT_W        = 32,
    parameter int DEFAULT_HALF = 250000000,
    localparam int CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             iclk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic             sync,
    input  logic             cfg_valid,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic [NCH-1:0]   pending,
    output logic [NCH-1:0]   oclk,
    output logic [NCH-1:0]   otick
);

    // Channel numbers with no lane behind them stay ready so writes drain.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++)
            if (cfg_ch == CH_W'(i)) cfg_ready = ~pending[i];
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        multi_clockdiv_lane #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_lane (
            .iclk    (iclk),
            .rst     (rst),
            .en      (en[i]),
            .sync    (sync),
            .wr      (cfg_valid && cfg_ready && (cfg_ch == CH_W'(i))),
            .wr_half (cfg_half),
            .pending (pending[i]),
            .oclk    (oclk[i]),
            .otick   (otick[i])
        );
    end

endmodule

module multi_clockdiv_lane #(
    parameter int CNT_W        = 32,
    parameter int DEFAULT_HALF = 250000000
) (
    input  logic             iclk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_half,
    output logic             pending,
    output logic             oclk,
    output logic             otick
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] pend_val;
    logic             at_end;

    // >= rather than == so a count beyond the half-period still terminates.
    assign at_end = (count >= (active - CNT_W'(1)));

    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            oclk     <= 1'b0;
            otick    <= 1'b0;
            pending  <= 1'b0;
            pend_val <= '0;
            active   <= CNT_W'(DEFAULT_HALF);
        end else begin
            if (sync) begin
                count <= '0;
                oclk  <= 1'b0;
                otick <= 1'b0;
            end else if (!en) begin
                otick <= 1'b0;
                if (pending) begin
                    active  <= pend_val;
                    pending <= 1'b0;
                    count   <= '0;
                    oclk    <= 1'b0;
                end
            end else if (at_end) begin
                count <= '0;
                oclk  <= ~oclk;
                otick <= ~oclk;
                // Falling edge closes a full period: safe point to swap divisor.
                if (oclk && pending) begin
                    active  <= pend_val;
                    pending <= 1'b0;
                end
            end else begin
                count <= count + CNT_W'(1);
                otick <= 1'b0;
            end
            // A write is only accepted while pending is clear, so it never races the clear above.
            if (wr) begin
                pending  <= 1'b1;
                pend_val <= (wr_half == '0) ? CNT_W'(1) : wr_half;
            end
        end
    end

endmodule
